// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the five-stage MIPS pipeline.
//
// Captures the execute-stage outputs in the EX/MEM register every cycle (no
// stall), performs word loads/stores against an internal 2^ADDR_W x 32 RAM,
// and presents the MEM/WB-bound values plus a pre-muxed forwarding result.
//
// Ports:
//   clk, rst_n         clock (rising edge) and synchronous active-low reset
//   ex_*               execute-stage control/data (wreg, m2reg, wmem, aluR,
//                      inB, destR) and EXE_ins_type/EXE_ins_number tags
//   mem_*              registered control/data, load data and forwarding mux
//   MEM_ins_type/number registered tags
//   dbg_addr/dbg_data  combinational read-only RAM word port for display
module mem_stage #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic              ex_wmem,
    input  logic [31:0]       ex_aluR,
    input  logic [31:0]       ex_inB,
    input  logic [4:0]        ex_destR,
    input  logic [3:0]        EXE_ins_type,
    input  logic [3:0]        EXE_ins_number,
    output logic              mem_wreg,
    output logic              mem_m2reg,
    output logic [31:0]       mem_aluR,
    output logic [31:0]       mem_mdata,
    output logic [31:0]       mem_result,
    output logic [4:0]        mem_destR,
    output logic [3:0]        MEM_ins_type,
    output logic [3:0]        MEM_ins_number,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu_r;
        logic [31:0] in_b;
        logic [4:0]  dest_r;
        logic [3:0]  ins_type;
        logic [3:0]  ins_num;
    } exmem_t;

    exmem_t            exmem;
    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;

    // Zero-filled RAM at start; FPGA flows honour this as the init image.
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
    end

    // EX/MEM register: loads every cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem <= '0;
        end else begin
            exmem <= '{wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem,
                       alu_r: ex_aluR, in_b: ex_inB, dest_r: ex_destR,
                       ins_type: EXE_ins_type, ins_num: EXE_ins_number};
        end
    end

    // Byte offset and high address bits are dropped: misaligned accesses hit
    // the containing word and addresses wrap around the RAM size.
    assign word_idx = exmem.alu_r[ADDR_W+1:2];

    // Store at the edge closing the MEM cycle; a reset on that edge kills it.
    always_ff @(posedge clk) begin
        if (rst_n && exmem.wmem) ram[word_idx] <= exmem.in_b;
    end

    // Asynchronous reads give read-before-write within the store's own cycle.
    assign mem_mdata      = ram[word_idx];
    assign dbg_data       = ram[dbg_addr];
    assign mem_result     = exmem.m2reg ? mem_mdata : exmem.alu_r;

    assign mem_wreg       = exmem.wreg;
    assign mem_m2reg      = exmem.m2reg;
    assign mem_aluR       = exmem.alu_r;
    assign mem_destR      = exmem.dest_r;
    assign MEM_ins_type   = exmem.ins_type;
    assign MEM_ins_number = exmem.ins_num;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int ADDR_W = 6;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_wreg, ex_m2reg, ex_wmem;
    logic [31:0]       ex_aluR, ex_inB;
    logic [4:0]        ex_destR;
    logic [3:0]        EXE_ins_type, EXE_ins_number;
    logic              mem_wreg, mem_m2reg;
    logic [31:0]       mem_aluR, mem_mdata, mem_result;
    logic [4:0]        mem_destR;
    logic [3:0]        MEM_ins_type, MEM_ins_number;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a word array plus the instruction currently in MEM.
    logic [31:0] m_ram [WORDS];
    logic        m_wreg, m_m2reg, m_wmem;
    logic [31:0] m_alu, m_inb;
    logic [4:0]  m_dest;
    logic [3:0]  m_type, m_num;

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_aluR(mem_aluR),
        .mem_mdata(mem_mdata), .mem_result(mem_result), .mem_destR(mem_destR),
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Byte address -> word slot: drop byte offset, wrap modulo RAM size.
    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic logic [31:0] exp_mdata();
        return m_ram[widx(m_alu)];
    endfunction

    // Advance one clock: apply the model's edge behaviour, then sample at negedge.
    task automatic tick();
        if (rst_n && m_wmem) m_ram[widx(m_alu)] = m_inb;
        if (!rst_n) begin
            {m_wreg, m_m2reg, m_wmem, m_alu, m_inb, m_dest, m_type, m_num} = '0;
        end else begin
            m_wreg = ex_wreg; m_m2reg = ex_m2reg; m_wmem = ex_wmem;
            m_alu = ex_aluR; m_inb = ex_inB; m_dest = ex_destR;
            m_type = EXE_ins_type; m_num = EXE_ins_number;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic m2, input logic wm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [3:0] t, input logic [3:0] n);
        ex_wreg = w; ex_m2reg = m2; ex_wmem = wm; ex_aluR = a; ex_inB = b;
        ex_destR = d; EXE_ins_type = t; EXE_ins_number = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD, 5'd9, 4'd1, 4'd2);
        tick();
        tick();
        dbg_addr = 6'd4;
        #1;
        vectors++;
        if ({mem_wreg, mem_m2reg, mem_aluR, mem_destR, MEM_ins_type, MEM_ins_number} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: wreg=%0b m2reg=%0b aluR=%h destR=%0d type=%0d num=%0d, want all 0",
                     mem_wreg, mem_m2reg, mem_aluR, mem_destR, MEM_ins_type, MEM_ins_number);
        end
        vectors++;
        if (dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dbg4: got %h want 00000000", dbg_data);
        end
    endtask

    task automatic test_store_load();
        rst_n = 1'b1;
        dbg_addr = 6'd8;
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0, 4'd2, 4'd1);
        tick();
        // Store is in MEM: both read ports still see the old word.
        vectors++;
        if (dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rbw_dbg: got %h want 00000000", dbg_data);
        end
        vectors++;
        if (mem_mdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rbw_mdata: got %h want 00000000", mem_mdata);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd5, 4'd1, 4'd2);
        tick();
        vectors++;
        if (mem_mdata !== 32'h12345678 || mem_result !== 32'h12345678) begin
            miscompares++;
            $display("FAIL load_data: mdata=%h result=%h want 12345678", mem_mdata, mem_result);
        end
        vectors++;
        if (mem_m2reg !== 1'b1 || mem_destR !== 5'd5) begin
            miscompares++;
            $display("FAIL load_ctrl: m2reg=%0b destR=%0d want 1/5", mem_m2reg, mem_destR);
        end
        vectors++;
        if (dbg_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL dbg_after_store: got %h want 12345678", dbg_data);
        end
    endtask

    task automatic test_alias();
        drive(1'b0, 1'b0, 1'b1, 32'h23, 32'hA5A5A5A5, 5'd0, 4'd2, 4'd3);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd6, 4'd1, 4'd4);
        tick();
        vectors++;
        if (mem_result !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL alias_misaligned: got %h want a5a5a5a5", mem_result);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h120, 32'h0, 5'd7, 4'd1, 4'd5);
        tick();
        vectors++;
        if (mem_mdata !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL alias_wrap: got %h want a5a5a5a5", mem_mdata);
        end
    endtask

    task automatic test_passthrough();
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF0001, 32'hCAFEF00D, 5'd3, 4'd3, 4'd7);
        tick();
        vectors++;
        if (mem_result !== 32'hFFFF0001 || mem_wreg !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_result: result=%h wreg=%0b want ffff0001/1", mem_result, mem_wreg);
        end
        vectors++;
        if (MEM_ins_type !== 4'd3 || MEM_ins_number !== 4'd7) begin
            miscompares++;
            $display("FAIL pass_tags: type=%0d num=%0d want 3/7", MEM_ins_type, MEM_ins_number);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 4'd0);
        tick();
        dbg_addr = 6'd0;
        #1;
        vectors++;
        if (dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL pass_ram0_unchanged: got %h want 00000000", dbg_data);
        end
    endtask

    task automatic test_reset_mid_store();
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h55, 5'd0, 4'd2, 4'd8);
        tick();
        rst_n = 1'b0;
        tick();
        dbg_addr = 6'd16;
        #1;
        vectors++;
        if (dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_store_ram16: got %h want 00000000", dbg_data);
        end
        vectors++;
        if ({mem_wreg, mem_m2reg, mem_aluR, mem_destR, MEM_ins_type, MEM_ins_number} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_store_outputs: aluR=%h type=%0d num=%0d want 0",
                     mem_aluR, MEM_ins_type, MEM_ins_number);
        end
        rst_n = 1'b1;
    endtask

    // Random traffic over a narrow address window to force hits and aliases.
    task automatic test_random();
        logic [31:0] a;
        for (int c = 0; c < 300; c++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            a = {($urandom_range(0, 3) == 0) ? $urandom() : 32'h0} | 32'($urandom_range(0, 255));
            drive(1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), a, $urandom(),
                  5'($urandom), 4'($urandom), 4'($urandom));
            tick();
            dbg_addr = ADDR_W'($urandom);
            #1;
            vectors++;
            if (mem_wreg !== m_wreg || mem_m2reg !== m_m2reg || mem_aluR !== m_alu ||
                mem_destR !== m_dest || MEM_ins_type !== m_type || MEM_ins_number !== m_num) begin
                miscompares++;
                $display("FAIL rand_regs c=%0d: got %0b %0b %h %0d %0d %0d want %0b %0b %h %0d %0d %0d", c,
                         mem_wreg, mem_m2reg, mem_aluR, mem_destR, MEM_ins_type, MEM_ins_number,
                         m_wreg, m_m2reg, m_alu, m_dest, m_type, m_num);
            end
            vectors++;
            if (mem_mdata !== exp_mdata() || mem_result !== (m_m2reg ? exp_mdata() : m_alu)) begin
                miscompares++;
                $display("FAIL rand_data c=%0d: mdata=%h result=%h want %h %h", c, mem_mdata, mem_result,
                         exp_mdata(), m_m2reg ? exp_mdata() : m_alu);
            end
            vectors++;
            if (dbg_data !== m_ram[dbg_addr]) begin
                miscompares++;
                $display("FAIL rand_dbg c=%0d addr=%0d: got %h want %h", c, dbg_addr, dbg_data, m_ram[dbg_addr]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) m_ram[i] = '0;
        m_wmem = 1'b0;
        dbg_addr = '0;
        test_reset();
        test_store_load();
        test_alias();
        test_passthrough();
        test_reset_mid_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
